// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus: req/gnt address phase, in-order rvalid data phase.
interface fetch_stage_if #(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DATA_WIDTH    = 32
);
   logic                     imem_req;
   logic [ADDRESS_WIDTH-1:0] imem_addr;
   logic                     imem_gnt;
   logic                     imem_rvalid;
   logic [DATA_WIDTH-1:0]    imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: fetch PC, 2-entry in-order instruction queue, and a discard counter
// that drops responses still in flight when execute redirects the PC.
module fetch_stage #(
   parameter int unsigned             ADDRESS_WIDTH = 32,
   parameter int unsigned             DATA_WIDTH    = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC     = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     stall_f,
   input  logic                     pc_src_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
   fetch_stage_if.master            imem,
   output logic                     valid_f,
   output logic [DATA_WIDTH-1:0]    instr_f,
   output logic [ADDRESS_WIDTH-1:0] pc_f,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_f
);

   localparam logic [DATA_WIDTH-1:0]    NopInstr = DATA_WIDTH'(32'h0000_0013);
   localparam logic [ADDRESS_WIDTH-1:0] Four     = ADDRESS_WIDTH'(4);
   localparam logic [ADDRESS_WIDTH-1:0] WordMask = ~ADDRESS_WIDTH'(3);

   logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDRESS_WIDTH-1:0] ent_pc_q [2];
   logic [ADDRESS_WIDTH-1:0] ent_pc_d [2];
   logic [DATA_WIDTH-1:0]    ent_instr_q [2];
   logic [DATA_WIDTH-1:0]    ent_instr_d [2];
   logic [1:0]               ent_filled_q, ent_filled_d;
   logic                     head_q, head_d;
   logic [1:0]               count_q, count_d;
   logic [1:0]               discard_q, discard_d;
   logic [ADDRESS_WIDTH-1:0] last_pc_q, last_pc_d;

   logic       head_valid, pop, accept, drop, fill_hit, has_unfilled, fill_idx, tail_idx;
   logic [1:0] present, unfilled, unfilled_cnt;
   logic [2:0] inflight;

   // Queue bookkeeping shared by the next-state and output logic
   always_comb begin
      present           = '0;
      present[head_q]   = (count_q != 2'd0);
      present[~head_q]  = (count_q == 2'd2);
      unfilled          = present & ~ent_filled_q;
      has_unfilled      = |unfilled;
      unfilled_cnt      = 2'(unfilled[0]) + 2'(unfilled[1]);
      fill_idx          = unfilled[head_q] ? head_q : ~head_q;
      tail_idx          = head_q ^ count_q[0];
      head_valid        = (count_q != 2'd0) && ent_filled_q[head_q];
      valid_f           = head_valid && !pc_src_e;
      pop               = valid_f && !stall_f;
      inflight          = 3'(count_q) + 3'(discard_q) - 3'(pop);
      imem.imem_req     = rst_n && !pc_src_e && (inflight < 3'd2);
      imem.imem_addr    = fetch_pc_q;
      accept            = imem.imem_req && imem.imem_gnt;
      drop              = imem.imem_rvalid && (discard_q != 2'd0);
      fill_hit          = imem.imem_rvalid && (discard_q == 2'd0) && has_unfilled;
   end

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      ent_pc_d     = ent_pc_q;
      ent_instr_d  = ent_instr_q;
      ent_filled_d = ent_filled_q;
      head_d       = head_q;
      count_d      = count_q;
      discard_d    = discard_q;
      last_pc_d    = valid_f ? ent_pc_q[head_q] : last_pc_q;

      if (pc_src_e) begin
         // Every entry still waiting on memory after this cycle's fill becomes a discard
         fetch_pc_d   = pc_target_e & WordMask;
         ent_filled_d = '0;
         head_d       = 1'b0;
         count_d      = 2'd0;
         discard_d    = discard_q + unfilled_cnt - 2'(drop) - 2'(fill_hit);
      end else begin
         if (drop) begin
            discard_d = discard_q - 2'd1;
         end else if (fill_hit) begin
            ent_instr_d[fill_idx]  = imem.imem_rdata;
            ent_filled_d[fill_idx] = 1'b1;
         end
         if (pop) begin
            head_d = ~head_q;
         end
         if (accept) begin
            ent_pc_d[tail_idx]     = fetch_pc_q;
            ent_filled_d[tail_idx] = 1'b0;
            fetch_pc_d             = fetch_pc_q + Four;
         end
         count_d = count_q - 2'(pop) + 2'(accept);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q   <= RESET_PC;
         ent_filled_q <= '0;
         head_q       <= 1'b0;
         count_q      <= 2'd0;
         discard_q    <= 2'd0;
         last_pc_q    <= '0;
         for (int i = 0; i < 2; i++) begin
            ent_pc_q[i]    <= '0;
            ent_instr_q[i] <= '0;
         end
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         ent_pc_q     <= ent_pc_d;
         ent_instr_q  <= ent_instr_d;
         ent_filled_q <= ent_filled_d;
         head_q       <= head_d;
         count_q      <= count_d;
         discard_q    <= discard_d;
         last_pc_q    <= last_pc_d;
      end
   end

   always_comb begin
      pc_f       = valid_f ? ent_pc_q[head_q] : last_pc_q;
      instr_f    = valid_f ? ent_instr_q[head_q] : NopInstr;
      pc_plus4_f = pc_f + Four;
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: two instances (RESET_PC 0 and 0xFFFFFFF8) in lockstep,
// each with an in-order memory model that can hold its responses back.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall_f;
   logic        pc_src_e;
   logic [31:0] pc_target_e;
   logic        hold;

   logic        valid_f,  valid2;
   logic [31:0] instr_f,  instr2;
   logic [31:0] pc_f,     pc2;
   logic [31:0] pc_plus4_f, pc4_2;

   logic [31:0] mq1 [$];
   logic [31:0] mq2 [$];

   int n_tests = 0;
   int n_fail  = 0;

   fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus  ();
   fetch_stage_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

   fetch_stage #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH   (32),
      .RESET_PC     (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_f    (stall_f),
      .pc_src_e   (pc_src_e),
      .pc_target_e(pc_target_e),
      .imem       (bus),
      .valid_f    (valid_f),
      .instr_f    (instr_f),
      .pc_f       (pc_f),
      .pc_plus4_f (pc_plus4_f)
   );

   fetch_stage #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH   (32),
      .RESET_PC     (32'hFFFF_FFF8)
   ) dut_wrap (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_f    (stall_f),
      .pc_src_e   (pc_src_e),
      .pc_target_e(pc_target_e),
      .imem       (bus2),
      .valid_f    (valid2),
      .instr_f    (instr2),
      .pc_f       (pc2),
      .pc_plus4_f (pc4_2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; drives this cycle's inputs and lets outputs settle.
   task automatic set_in(input logic st, input logic src, input logic [31:0] tgt, input logic g);
      stall_f          = st;
      pc_src_e         = src;
      pc_target_e      = tgt;
      bus.imem_gnt     = g;
      bus2.imem_gnt    = g;
      bus.imem_rvalid  = !hold && (mq1.size() > 0);
      bus.imem_rdata   = bus.imem_rvalid ? word(mq1[0]) : 32'h0;
      bus2.imem_rvalid = !hold && (mq2.size() > 0);
      bus2.imem_rdata  = bus2.imem_rvalid ? word(mq2[0]) : 32'h0;
      #1;
   endtask

   task automatic tick();
      logic        acc1, acc2, rv1, rv2;
      logic [31:0] a1, a2;
      acc1 = bus.imem_req && bus.imem_gnt;
      acc2 = bus2.imem_req && bus2.imem_gnt;
      a1   = bus.imem_addr;
      a2   = bus2.imem_addr;
      rv1  = bus.imem_rvalid;
      rv2  = bus2.imem_rvalid;
      @(posedge clk);
      @(negedge clk);
      if (rv1) void'(mq1.pop_front());
      if (rv2) void'(mq2.pop_front());
      if (acc1) mq1.push_back(a1);
      if (acc2) mq2.push_back(a2);
   endtask

   initial begin
      rst_n = 1'b0;
      hold  = 1'b0;
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      @(negedge clk);
      #1;
      check("rst_valid", valid_f, 32'h0);
      check("rst_instr", instr_f, 32'h13);
      check("rst_pc", pc_f, 32'h0);
      check("rst_pc4", pc_plus4_f, 32'h4);
      check("rst_req", bus.imem_req, 32'h0);
      check("rst_req_w", bus2.imem_req, 32'h0);
      check("rst_pc_w", pc2, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Streaming from reset
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("c0_req", bus.imem_req, 32'h1);
      check("c0_addr", bus.imem_addr, 32'h0);
      check("c0_valid", valid_f, 32'h0);
      check("c0_addr_w", bus2.imem_addr, 32'hFFFF_FFF8);
      tick();
      for (int k = 1; k <= 5; k++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b1);
         check("s_req", bus.imem_req, 32'h1);
         check("s_addr", bus.imem_addr, 32'(4 * k));
         if (k == 1) begin
            check("s_valid1", valid_f, 32'h0);
            check("w_addr1", bus2.imem_addr, 32'hFFFF_FFFC);
         end else begin
            check("s_valid", valid_f, 32'h1);
            check("s_pc", pc_f, 32'(4 * (k - 2)));
            check("s_pc4", pc_plus4_f, 32'(4 * (k - 1)));
            check("s_instr", instr_f, word(32'(4 * (k - 2))));
         end
         if (k == 2) begin
            check("w_addr2", bus2.imem_addr, 32'h0);
            check("w_valid2", valid2, 32'h1);
            check("w_pc2", pc2, 32'hFFFF_FFF8);
            check("w_pc4_2", pc4_2, 32'hFFFF_FFFC);
         end
         if (k == 3) begin
            check("w_pc3", pc2, 32'hFFFF_FFFC);
            check("w_pc4_3", pc4_2, 32'h0);
            check("w_instr3", instr2, word(32'hFFFF_FFFC));
         end
         tick();
      end

      // Stall three cycles with a full queue
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 1'b0, 32'h0, 1'b1);
         check("st_valid", valid_f, 32'h1);
         check("st_pc", pc_f, 32'd16);
         check("st_instr", instr_f, word(32'd16));
         check("st_req", bus.imem_req, 32'h0);
         tick();
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rel_pc16", pc_f, 32'd16);
      check("rel_req", bus.imem_req, 32'h1);
      check("rel_addr", bus.imem_addr, 32'd24);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rel_pc20", pc_f, 32'd20);
      check("rel_instr20", instr_f, word(32'd20));
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rel_pc24", pc_f, 32'd24);
      check("rel_addr32", bus.imem_addr, 32'd32);
      tick();

      // Redirect to 0x103 with two responses held in flight
      hold = 1'b1;
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("pre_pc28", pc_f, 32'd28);
      check("pre_addr36", bus.imem_addr, 32'd36);
      tick();
      set_in(1'b0, 1'b1, 32'h0000_0103, 1'b1);
      check("rd_req", bus.imem_req, 32'h0);
      check("rd_valid", valid_f, 32'h0);
      check("rd_pc_hold", pc_f, 32'd28);
      check("rd_instr", instr_f, 32'h13);
      tick();
      hold = 1'b0;
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd1_req", bus.imem_req, 32'h0);
      check("rd1_valid", valid_f, 32'h0);
      check("rd1_pc", pc_f, 32'd28);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd2_valid", valid_f, 32'h0);
      check("rd2_req", bus.imem_req, 32'h1);
      check("rd2_addr", bus.imem_addr, 32'h100);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd3_valid", valid_f, 32'h0);
      check("rd3_addr", bus.imem_addr, 32'h104);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rd4_valid", valid_f, 32'h1);
      check("rd4_pc", pc_f, 32'h100);
      check("rd4_instr", instr_f, word(32'h100));
      check("rd4_pc4", pc_plus4_f, 32'h104);
      tick();

      // Grant withheld for four cycles
      for (int k = 0; k < 4; k++) begin
         set_in(1'b0, 1'b0, 32'h0, 1'b0);
         check("ng_req", bus.imem_req, 32'h1);
         check("ng_addr", bus.imem_addr, 32'h10C);
         if (k == 0) check("ng_pc104", pc_f, 32'h104);
         if (k == 1) check("ng_pc108", pc_f, 32'h108);
         if (k == 2) check("ng_valid", valid_f, 32'h0);
         tick();
      end
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("g_addr10c", bus.imem_addr, 32'h10C);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("g_addr110", bus.imem_addr, 32'h110);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("g_pc10c", pc_f, 32'h10C);
      check("g_instr10c", instr_f, word(32'h10C));
      tick();

      // Fill the queue under stall, then pulse reset mid-cycle
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      check("f_pc110", pc_f, 32'h110);
      check("f_req", bus.imem_req, 32'h0);
      tick();
      set_in(1'b1, 1'b0, 32'h0, 1'b1);
      check("f_valid", valid_f, 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_valid", valid_f, 32'h0);
      check("ar_instr", instr_f, 32'h13);
      check("ar_pc", pc_f, 32'h0);
      check("ar_pc4", pc_plus4_f, 32'h4);
      check("ar_req", bus.imem_req, 32'h0);
      @(negedge clk);
      mq1.delete();
      mq2.delete();
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rr_req", bus.imem_req, 32'h1);
      check("rr_addr", bus.imem_addr, 32'h0);
      check("rr_addr_w", bus2.imem_addr, 32'hFFFF_FFF8);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rr_addr4", bus.imem_addr, 32'h4);
      tick();
      set_in(1'b0, 1'b0, 32'h0, 1'b1);
      check("rr_valid", valid_f, 32'h1);
      check("rr_pc", pc_f, 32'h0);
      check("rr_instr", instr_f, word(32'h0));
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage feeding the decode stage. Holds the architectural fetch PC and issues word requests to instruction memory over a req/gnt request and rvalid response handshake. Buffers up to two instructions so the memory can run ahead while decode is stalled. Redirects to a new PC on a taken branch or jump from execute, dropping any stale in-flight responses.

## Interface
- ADDRESS_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 0, PC fetched first after reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_f  in  1  hazard unit: hold current output instruction
- pc_src_e  in  1  redirect strobe from execute (taken branch/jump)
- pc_target_e  in  ADDRESS_WIDTH  redirect target; bits [1:0] ignored, treated as 0
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDRESS_WIDTH  fetch address (= fetch PC)
- imem_gnt  in  1  request accepted when imem_req && imem_gnt
- imem_rvalid  in  1  response valid; responses in request order, ≥1 cycle after acceptance
- imem_rdata  in  DATA_WIDTH  response instruction
- valid_f  out  1  instr_f/pc_f/pc_plus4_f hold a real instruction
- instr_f  out  DATA_WIDTH  instruction to decode; 32'h00000013 (NOP) when !valid_f
- pc_f  out  ADDRESS_WIDTH  PC of instr_f
- pc_plus4_f  out  ADDRESS_WIDTH  pc_f + 4, modulo 2^ADDRESS_WIDTH

## Operation
- State: fetch PC; 2-entry in-order queue, each entry {pc, instr, filled}; 2-bit discard counter (0..2).
- Allocation: on request acceptance, push entry {pc = fetch PC, filled = 0}; fetch PC <= fetch PC + 4 (wraps).
- Fill: on imem_rvalid, if discard > 0 then discard decrements and data dropped; else oldest unfilled entry gets instr = imem_rdata, filled = 1.
- Output: head entry drives pc_f/instr_f; valid_f = head present && head filled. When !valid_f, pc_f/pc_plus4_f hold last presented values (0/4 after reset).
- Pop: head popped when valid_f && !stall_f.
- Credit: imem_req = !pc_src_e && (occupancy − pop + discard) < 2. Total outstanding plus buffered never exceeds 2; queue cannot overflow. Combinational path stall_f → imem_req is permitted.
- Redirect (pc_src_e = 1): fetch PC <= {pc_target_e[AW-1:2], 2'b00}; all queue entries cleared; discard <= discard + (unfilled entries, excluding one being filled this cycle) + (1 if that cycle's rvalid is itself dropped? no — count only entries still outstanding after this cycle's fill); valid_f forced 0 same cycle; imem_req forced 0 that cycle.
- Priority: reset > redirect > stall. Redirect during stall still flushes.
- Fill and pop of same entry in one cycle impossible (fill registers first).
- imem_addr stable while imem_req high and not granted, except across a redirect (req drops).

## Timing
- Reset (async, rst_n low): fetch PC = RESET_PC, queue empty, discard = 0; valid_f = 0, instr_f = NOP, pc_f = 0, pc_plus4_f = 4, imem_req = 0 while rst_n low.
- First cycle after rst_n rises: imem_req = 1, imem_addr = RESET_PC.
- Latency: accepted cycle n, rvalid cycle n+1 → valid_f cycle n+2.
- Throughput: with gnt = 1 and 1-cycle rvalid, one instruction per cycle while !stall_f.
- Redirect in cycle n: first request to target issued cycle n+1; its instruction valid at n+3 at the earliest.
- Reset asserted mid-operation clears all state immediately; late responses after reset release are the memory's responsibility to suppress.

## Test plan
- Reset release, gnt = 1, 1-cycle rvalid returning addr-based words: addresses 0,4,8,… issued every cycle; valid_f from cycle 3 with pc_f 0,4,8, pc_plus4_f = pc_f + 4.
- stall_f high 3 cycles in steady stream: instr_f/pc_f held; imem_req drops after queue + outstanding reach 2; no instruction lost or duplicated after release.
- pc_src_e with pc_target_e = 0x103 while 2 requests outstanding: both responses dropped, valid_f low until fetch of 0x100 returns, next pc_f = 0x100.
- imem_gnt held low 4 cycles: imem_req high, imem_addr constant; fetch PC advances only on grant.
- RESET_PC = 0xFFFFFFF8, ADDRESS_WIDTH = 32: addresses FFFFFFF8, FFFFFFFC, 00000000; pc_plus4_f for FFFFFFFC = 0.
- rst_n pulsed low mid-stream with queue full: outputs return to reset values asynchronously; fetch restarts at RESET_PC.
